// File: rtl/data_memory_load_controller.sv
// Sequences DataMemory between a host preload stream (LOAD) and a write-free CGRA run window (RUN).
// Optional macro DATA_MEMORY_LOAD_CHECKSUM_EN adds a running sum of the loaded words on load_checksum.
module data_memory_load_controller #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int MEMORY_SIZE   = 256,
  parameter int RUN_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_load,
  input  logic [ADDRESS_WIDTH-1:0] load_base,
  input  logic [ADDRESS_WIDTH:0]   load_count,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  input  logic                     start_run,
  input  logic [RUN_CNT_WIDTH-1:0] run_cycles,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic                     exec_enable,
  output logic                     busy,
  output logic                     load_done,
  output logic                     run_done,
  output logic                     load_error,
  output logic [DATA_WIDTH-1:0]    load_checksum
);

  localparam logic [ADDRESS_WIDTH+1:0] MEM_LIMIT = (ADDRESS_WIDTH+2)'(MEMORY_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_base;
  logic [ADDRESS_WIDTH-1:0] r_index;
  logic [ADDRESS_WIDTH:0]   r_remaining;
  logic                     r_in_ready;
  logic                     r_mem_write;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_exec_en;
  logic [RUN_CNT_WIDTH-1:0] r_run_cnt;
  logic                     r_load_done;
  logic                     r_run_done;
  logic                     r_load_error;

  logic                     w_idle;
  logic [ADDRESS_WIDTH+1:0] w_load_end;
  logic                     w_load_ok;
  logic                     w_load_acc;
  logic                     w_load_rej;
  logic                     w_run_req;
  logic                     w_run_acc;
  logic                     w_run_zero;
  logic                     w_beat;
  logic                     w_last_beat;
  logic                     w_run_last;
  logic                     w_in_ready_nxt;
  logic                     w_exec_nxt;
  logic                     w_busy;

  // Range check is done one bit wider than the sum so an overrun can never wrap.
  assign w_idle      = (r_state == S_IDLE);
  assign w_load_end  = {2'b00, load_base} + {1'b0, load_count};
  assign w_load_ok   = (load_count != '0) && (w_load_end <= MEM_LIMIT);
  assign w_load_acc  = w_idle && start_load && w_load_ok;
  assign w_load_rej  = w_idle && start_load && !w_load_ok;
  assign w_run_req   = w_idle && start_run && !start_load;
  assign w_run_acc   = w_run_req && (run_cycles != '0);
  assign w_run_zero  = w_run_req && (run_cycles == '0);
  assign w_beat      = r_in_ready && in_valid;
  assign w_last_beat = w_beat && (r_remaining == (ADDRESS_WIDTH+1)'(1));
  assign w_run_last  = r_exec_en && (r_run_cnt == RUN_CNT_WIDTH'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // LOAD/RUN are held through the done-pulse cycle so busy covers it.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_load_acc) begin
          w_state_nxt = S_LOAD;
        end else if (w_run_acc) begin
          w_state_nxt = S_RUN;
        end
      end
      S_LOAD: if (r_load_done) w_state_nxt = S_IDLE;
      S_RUN:  if (r_run_done)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy         = (r_state != S_IDLE);
    w_in_ready_nxt = r_in_ready;
    w_exec_nxt     = r_exec_en;
    if (w_load_acc) begin
      w_in_ready_nxt = 1'b1;
    end else if (w_last_beat) begin
      w_in_ready_nxt = 1'b0;
    end
    if (w_run_acc) begin
      w_exec_nxt = 1'b1;
    end else if (w_run_last) begin
      w_exec_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base       <= '0;
      r_index      <= '0;
      r_remaining  <= '0;
      r_in_ready   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_exec_en    <= 1'b0;
      r_run_cnt    <= '0;
      r_load_done  <= 1'b0;
      r_run_done   <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_in_ready   <= w_in_ready_nxt;
      r_exec_en    <= w_exec_nxt;
      r_mem_write  <= w_beat;
      r_load_done  <= w_last_beat;
      r_load_error <= w_load_rej;
      r_run_done   <= w_run_last || w_run_zero;
      if (w_beat) begin
        r_addr <= r_base + r_index;
        r_data <= in_data;
      end
      if (w_load_acc) begin
        r_base      <= load_base;
        r_index     <= '0;
        r_remaining <= load_count;
      end else if (w_beat) begin
        r_index     <= r_index + ADDRESS_WIDTH'(1);
        r_remaining <= r_remaining - (ADDRESS_WIDTH+1)'(1);
      end
      if (w_run_acc) begin
        r_run_cnt <= run_cycles;
      end else if (r_exec_en) begin
        r_run_cnt <= r_run_cnt - RUN_CNT_WIDTH'(1);
      end
    end
  end

`ifdef DATA_MEMORY_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_checksum <= '0;
    end else if (w_load_acc) begin
      r_checksum <= '0;
    end else if (w_beat) begin
      r_checksum <= r_checksum + in_data;
    end
  end

  assign load_checksum = r_checksum;
`else
  assign load_checksum = '0;
`endif

  assign in_ready          = r_in_ready;
  assign mem_write         = r_mem_write;
  assign mem_write_address = r_addr;
  assign mem_write_data    = r_data;
  assign exec_enable       = r_exec_en;
  assign busy              = w_busy;
  assign load_done         = r_load_done;
  assign run_done          = r_run_done;
  assign load_error        = r_load_error;

endmodule

// File: tb/tb_data_memory_load_controller.sv
// Self-checking bench for data_memory_load_controller: directed spec scenarios plus randomized loads/runs
// checked against a write-list / memory-image model.
module tb_data_memory_load_controller;
  localparam int AW  = 6;
  localparam int DW  = 16;
  localparam int MEM = 48;
  localparam int RW  = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_load = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW:0]   load_count = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          start_run = 1'b0;
  logic [RW-1:0] run_cycles = '0;
  logic          mem_write;
  logic [AW-1:0] mem_write_address;
  logic [DW-1:0] mem_write_data;
  logic          exec_enable, busy, load_done, run_done, load_error;
  logic [DW-1:0] load_checksum;

  data_memory_load_controller #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEMORY_SIZE(MEM), .RUN_CNT_WIDTH(RW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_load(start_load), .load_base(load_base),
    .load_count(load_count), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start_run(start_run), .run_cycles(run_cycles), .mem_write(mem_write),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .exec_enable(exec_enable), .busy(busy), .load_done(load_done), .run_done(run_done),
    .load_error(load_error), .load_checksum(load_checksum)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observed activity, sampled on the falling edge and tagged with the cycle number.
  int            wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            exec_q[$];
  int            ld_done_q[$];
  int            rn_done_q[$];
  int            err_q[$];
  int            viol, busy_cnt;
  logic [DW-1:0] ck_at_done;
  logic          busy_at_done, rdy_at_done, exec_at_rdone;
  logic [DW-1:0] dut_mem[MEM];
  logic [DW-1:0] exp_mem[MEM];

  always @(negedge clk) begin
    if (mem_write) begin
      wr_addr_q.push_back(int'(mem_write_address));
      wr_data_q.push_back(mem_write_data);
      wr_cyc_q.push_back(cyc);
      if (int'(mem_write_address) < MEM) dut_mem[mem_write_address] = mem_write_data;
    end
    if (exec_enable) exec_q.push_back(cyc);
    if (mem_write && exec_enable) viol++;
    if (busy) busy_cnt++;
    if (load_done) begin
      ld_done_q.push_back(cyc);
      ck_at_done   = load_checksum;
      busy_at_done = busy;
      rdy_at_done  = in_ready;
    end
    if (run_done) begin
      rn_done_q.push_back(cyc);
      exec_at_rdone = exec_enable;
    end
    if (load_error) err_q.push_back(cyc);
  end

  // Driver state and load model inputs.
  logic [DW-1:0] ld_data[$];
  int            acc_cyc_q[$];
  int            start_cyc;
  int            ready_drops;
  bit            drv_timeout;

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); exec_q.delete();
    ld_done_q.delete(); rn_done_q.delete(); err_q.delete(); acc_cyc_q.delete();
    viol = 0; busy_cnt = 0; ready_drops = 0;
  endtask

  function automatic logic [DW-1:0] model_checksum(input int n);
    logic [DW-1:0] s = '0;
    for (int i = 0; i < n; i++) s = s + ld_data[i];
`ifdef DATA_MEMORY_LOAD_CHECKSUM_EN
    return s;
`else
    return '0;
`endif
  endfunction

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random valid. abort_after<0 means run to completion.
  task automatic drive_load(input int base, input int cnt, input int mode,
                            input bit with_run, input bit run_mid, input int abort_after);
    int idx = 0;
    int t = 0;
    @(posedge clk); #1;
    start_load = 1'b1; load_base = AW'(base); load_count = (AW+1)'(cnt);
    start_run = with_run; run_cycles = RW'(3);
    @(negedge clk); start_cyc = cyc;
    @(posedge clk); #1;
    start_load = 1'b0; start_run = 1'b0;
    while (idx < cnt && t < 400 && idx != abort_after) begin
      in_valid  = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
      in_data   = in_valid ? ld_data[idx] : DW'($urandom);
      start_run = run_mid && (t == 1);
      @(negedge clk);
      if (!in_ready) ready_drops++;
      if (in_valid && in_ready) begin
        acc_cyc_q.push_back(cyc);
        idx++;
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0; start_run = 1'b0;
    drv_timeout = (idx < cnt) && (idx != abort_after);
  endtask

  task automatic drive_run(input int n);
    @(posedge clk); #1;
    start_run = 1'b1; run_cycles = RW'(n);
    @(negedge clk); start_cyc = cyc;
    @(posedge clk); #1;
    start_run = 1'b0;
    repeat (n + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if ({in_ready, mem_write, exec_enable, busy, load_done, run_done, load_error} !== 7'b0)
      $display("FAIL reset_ctrl: got %b exp 0", {in_ready, mem_write, exec_enable, busy, load_done, run_done, load_error});
    else n_pass++;
    n_chk++; if (mem_write_address !== '0) $display("FAIL reset_addr: got %0h exp 0", mem_write_address); else n_pass++;
    n_chk++; if (mem_write_data !== '0) $display("FAIL reset_data: got %0h exp 0", mem_write_data); else n_pass++;
    n_chk++; if (load_checksum !== '0) $display("FAIL reset_checksum: got %0h exp 0", load_checksum); else n_pass++;
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({busy, in_ready} !== 2'b00) $display("FAIL reset_idle: got %b exp 00", {busy, in_ready}); else n_pass++;
  endtask

  task automatic test_load_back_to_back();
    int bad = 0;
    logic [DW-1:0] exp_ck;
    ld_data = '{16'h11, 16'h22, 16'h33};
`ifdef DATA_MEMORY_LOAD_CHECKSUM_EN
    exp_ck = 16'h66;
`else
    exp_ck = 16'h0;
`endif
    clear_mon();
    drive_load(4, 3, 0, 0, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (drv_timeout || ready_drops != 0) $display("FAIL b2b_ready: timeout %0d drops %0d exp 0 0", drv_timeout, ready_drops); else n_pass++;
    n_chk++; if (wr_addr_q.size() != 3) $display("FAIL b2b_nwrites: got %0d exp 3", wr_addr_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== 4 + i || wr_data_q[i] !== ld_data[i] || wr_cyc_q[i] !== acc_cyc_q[i] + 1) bad++;
    n_chk++; if (bad != 0) $display("FAIL b2b_writes: got %0d bad beats exp 0", bad); else n_pass++;
    n_chk++; if (wr_cyc_q.size() == 3 && wr_cyc_q[2] - wr_cyc_q[0] != 2) $display("FAIL b2b_consecutive: got span %0d exp 2", wr_cyc_q[2] - wr_cyc_q[0]); else n_pass++;
    n_chk++; if (ld_done_q.size() != 1 || ld_done_q[0] !== wr_cyc_q[2]) $display("FAIL b2b_done: got %0d pulses exp 1 with last write", ld_done_q.size()); else n_pass++;
    n_chk++; if (ck_at_done !== exp_ck) $display("FAIL b2b_checksum: got %0h exp %0h", ck_at_done, exp_ck); else n_pass++;
    n_chk++; if ({busy_at_done, rdy_at_done} !== 2'b10) $display("FAIL b2b_done_flags: got busy/rdy %b exp 10", {busy_at_done, rdy_at_done}); else n_pass++;
    n_chk++; if (busy_cnt != ld_done_q[0] - start_cyc) $display("FAIL b2b_busy: got %0d cycles exp %0d", busy_cnt, ld_done_q[0] - start_cyc); else n_pass++;
    drive_run(2);
    n_chk++; if (load_checksum !== exp_ck) $display("FAIL b2b_checksum_hold: got %0h exp %0h", load_checksum, exp_ck); else n_pass++;
  endtask

  task automatic test_load_gaps();
    int bad = 0;
    ld_data = '{16'h11, 16'h22, 16'h33};
    clear_mon();
    drive_load(4, 3, 1, 0, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (drv_timeout || ready_drops != 0) $display("FAIL gap_ready: timeout %0d drops %0d exp 0 0", drv_timeout, ready_drops); else n_pass++;
    n_chk++; if (wr_addr_q.size() != 3) $display("FAIL gap_nwrites: got %0d exp 3", wr_addr_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== 4 + i || wr_data_q[i] !== ld_data[i] || wr_cyc_q[i] !== acc_cyc_q[i] + 1) bad++;
    n_chk++; if (bad != 0) $display("FAIL gap_writes: got %0d bad beats exp 0", bad); else n_pass++;
    n_chk++; if (wr_cyc_q.size() == 3 && wr_cyc_q[2] - wr_cyc_q[0] != 4) $display("FAIL gap_spacing: got span %0d exp 4", wr_cyc_q[2] - wr_cyc_q[0]); else n_pass++;
    n_chk++; if (ld_done_q.size() != 1 || ck_at_done !== model_checksum(3)) $display("FAIL gap_done: got %0d pulses ck %0h exp 1 ck %0h", ld_done_q.size(), ck_at_done, model_checksum(3)); else n_pass++;
  endtask

  task automatic test_load_error();
    int bases[2] = '{MEM - 2, 7};
    int cnts[2]  = '{3, 0};
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      @(posedge clk); #1;
      start_load = 1'b1; load_base = AW'(bases[k]); load_count = (AW+1)'(cnts[k]);
      @(negedge clk); start_cyc = cyc;
      @(posedge clk); #1; start_load = 1'b0;
      in_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1; in_valid = 1'b0;
      n_chk++; if (err_q.size() != 1 || err_q[0] != start_cyc + 1) $display("FAIL err_pulse[%0d]: got %0d pulses exp 1 at %0d", k, err_q.size(), start_cyc + 1); else n_pass++;
      n_chk++; if (wr_addr_q.size() != 0 || busy_cnt != 0) $display("FAIL err_quiet[%0d]: got writes %0d busy %0d exp 0 0", k, wr_addr_q.size(), busy_cnt); else n_pass++;
    end
    // Exactly filling the top of memory is legal.
    ld_data = '{16'hA1, 16'hB2, 16'hC3};
    clear_mon();
    drive_load(MEM - 3, 3, 0, 0, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (err_q.size() != 0 || wr_addr_q.size() != 3 || wr_addr_q[2] != MEM - 1)
      $display("FAIL edge_load: got err %0d writes %0d exp 0 3 ending at %0d", err_q.size(), wr_addr_q.size(), MEM - 1);
    else n_pass++;
  endtask

  task automatic test_run();
    int lens[3] = '{5, 0, 1};
    for (int k = 0; k < 3; k++) begin
      int n = lens[k];
      int bad = 0;
      clear_mon();
      drive_run(n);
      for (int i = 0; i < exec_q.size(); i++) if (exec_q[i] != start_cyc + 1 + i) bad++;
      n_chk++; if (exec_q.size() != n || bad != 0) $display("FAIL run_exec[%0d]: got %0d cycles (%0d misplaced) exp %0d", n, exec_q.size(), bad, n); else n_pass++;
      n_chk++; if (rn_done_q.size() != 1 || rn_done_q[0] != start_cyc + n + 1 || exec_at_rdone !== 1'b0)
        $display("FAIL run_done[%0d]: got %0d pulses exp 1 at %0d with exec 0", n, rn_done_q.size(), start_cyc + n + 1);
      else n_pass++;
      n_chk++; if (wr_addr_q.size() != 0 || viol != 0) $display("FAIL run_nowrite[%0d]: got writes %0d viol %0d exp 0 0", n, wr_addr_q.size(), viol); else n_pass++;
      if (n > 0) begin
        n_chk++; if (busy_cnt != n + 1) $display("FAIL run_busy[%0d]: got %0d exp %0d", n, busy_cnt, n + 1); else n_pass++;
      end
    end
  endtask

  task automatic test_start_conflict();
    int bad = 0;
    ld_data = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    clear_mon();
    drive_load(20, 4, 0, 1, 1, -1);
    repeat (6) @(posedge clk);
    #1;
    n_chk++; if (exec_q.size() != 0 || rn_done_q.size() != 0) $display("FAIL conflict_run: got exec %0d done %0d exp 0 0", exec_q.size(), rn_done_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== 20 + i || wr_data_q[i] !== ld_data[i]) bad++;
    n_chk++; if (wr_addr_q.size() != 4 || bad != 0 || ld_done_q.size() != 1) $display("FAIL conflict_load: got writes %0d bad %0d done %0d exp 4 0 1", wr_addr_q.size(), bad, ld_done_q.size()); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL conflict_idle: got busy %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int bad = 0;
    ld_data = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    clear_mon();
    drive_load(10, 4, 0, 0, 0, 2);
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if ({in_ready, mem_write, exec_enable, busy, load_done, run_done, load_error} !== 7'b0 ||
                 mem_write_address !== '0 || mem_write_data !== '0 || load_checksum !== '0)
      $display("FAIL midreset_async: got ctrl %b addr %0h data %0h ck %0h exp all 0",
               {in_ready, mem_write, exec_enable, busy, load_done, run_done, load_error}, mem_write_address, mem_write_data, load_checksum);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (ld_done_q.size() != 0 || wr_addr_q.size() > 2 || busy !== 1'b0)
      $display("FAIL midreset_abort: got done %0d writes %0d busy %b exp 0 <=2 0", ld_done_q.size(), wr_addr_q.size(), busy);
    else n_pass++;
    ld_data = '{16'h0F0F, 16'h1111, 16'h2222, 16'h3333};
    clear_mon();
    drive_load(10, 4, 1, 0, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== 10 + i || wr_data_q[i] !== ld_data[i]) bad++;
    n_chk++; if (wr_addr_q.size() != 4 || bad != 0 || ld_done_q.size() != 1 || ck_at_done !== model_checksum(4))
      $display("FAIL midreset_fresh: got writes %0d bad %0d done %0d ck %0h exp 4 0 1 %0h", wr_addr_q.size(), bad, ld_done_q.size(), ck_at_done, model_checksum(4));
    else n_pass++;
  endtask

  task automatic test_random();
    int mism = 0;
    for (int a = 0; a < MEM; a++) begin dut_mem[a] = '0; exp_mem[a] = '0; end
    for (int it = 0; it < 10; it++) begin
      int base = $urandom_range(0, MEM - 1);
      int cnt  = $urandom_range(1, (MEM - base) < 8 ? (MEM - base) : 8);
      int n    = $urandom_range(0, 6);
      int bad  = 0;
      ld_data.delete();
      for (int i = 0; i < cnt; i++) ld_data.push_back(DW'($urandom));
      clear_mon();
      drive_load(base, cnt, 2, 0, 0, -1);
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < cnt; i++) exp_mem[base + i] = ld_data[i];
      for (int i = 0; i < cnt && i < wr_addr_q.size(); i++)
        if (wr_addr_q[i] !== base + i || wr_data_q[i] !== ld_data[i] || wr_cyc_q[i] !== acc_cyc_q[i] + 1) bad++;
      n_chk++; if (drv_timeout || wr_addr_q.size() != cnt || bad != 0 || err_q.size() != 0)
        $display("FAIL rnd_load[%0d]: got writes %0d bad %0d err %0d exp %0d 0 0", it, wr_addr_q.size(), bad, err_q.size(), cnt);
      else n_pass++;
      n_chk++; if (ld_done_q.size() != 1 || ld_done_q[0] != acc_cyc_q[cnt - 1] + 1 || ck_at_done !== model_checksum(cnt))
        $display("FAIL rnd_done[%0d]: got %0d pulses ck %0h exp 1 ck %0h", it, ld_done_q.size(), ck_at_done, model_checksum(cnt));
      else n_pass++;
      clear_mon();
      drive_run(n);
      n_chk++; if (exec_q.size() != n || rn_done_q.size() != 1 || viol != 0 || wr_addr_q.size() != 0)
        $display("FAIL rnd_run[%0d]: got exec %0d done %0d viol %0d exp %0d 1 0", it, exec_q.size(), rn_done_q.size(), viol, n);
      else n_pass++;
    end
    for (int a = 0; a < MEM; a++) if (dut_mem[a] !== exp_mem[a]) mism++;
    n_chk++; if (mism != 0) $display("FAIL rnd_image: got %0d differing words exp 0", mism); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_back_to_back();
    test_load_gaps();
    test_load_error();
    test_run();
    test_start_conflict();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
